// File: rtl/gold_code_scheduler.sv
// gold_code_scheduler: round-robin sharing of one Gold code generator, with reseed, warm-up and framed chip streaming.
module gold_code_scheduler #(
  parameter int NREQ    = 4,
  parameter int SHIFT_W = 5,
  parameter int LEN_W   = 10,
  parameter int WARMUP  = 32
) (
  input  logic                    clkin,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*SHIFT_W-1:0] req_shift,
  input  logic [NREQ*LEN_W-1:0]   req_len,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic                    gen_rstn,
  output logic [SHIFT_W-1:0]      gen_shift,
  input  logic                    gen_chip,
  output logic                    chip_out,
  output logic                    chip_valid,
  output logic                    chip_last
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = LEN_W > $clog2(WARMUP + 1) ? LEN_W : $clog2(WARMUP + 1);
  typedef enum logic [2:0] {IDLE, ARB, LOAD, WARM, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d, done_q, done_d;
  logic [PW-1:0] rr_q, rr_d, own_q, own_d, win;
  logic [PW:0] idx;
  logic [SHIFT_W-1:0] gen_shift_q, gen_shift_d;
  logic [LEN_W-1:0] len_q, len_d, win_len;
  logic [CW-1:0] cnt_q, cnt_d;
  logic chip_out_q, chip_out_d, chip_valid_q, chip_valid_d, chip_last_q, chip_last_d, abort;
  // scan downward in offset so the nearest set bit at or after rr_q wins
  always_comb begin
    win = rr_q;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_q} + (PW+1)'(k);
      idx = idx >= (PW+1)'(NREQ) ? idx - (PW+1)'(NREQ) : idx;
      if (req[idx[PW-1:0]]) win = idx[PW-1:0];
    end
    win_len = req_len[win*LEN_W +: LEN_W];
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    own_d = own_q;
    rr_d = rr_q;
    gen_shift_d = gen_shift_q;
    len_d = len_q;
    cnt_d = cnt_q;
    done_d = '0;
    chip_out_d = chip_out_q;
    chip_valid_d = 1'b0;
    chip_last_d = 1'b0;
    abort = !req[own_q] && (state_q == LOAD || state_q == WARM || state_q == RUN);
    case (state_q)
      IDLE: begin
        grant_d = '0;
        state_d = |req ? ARB : IDLE;
      end
      ARB: begin
        grant_d = NREQ'(1) << win;
        own_d = win;
        rr_d = win == PW'(NREQ - 1) ? '0 : win + 1'b1;
        gen_shift_d = req_shift[win*SHIFT_W +: SHIFT_W];
        len_d = win_len;
        state_d = win_len == '0 ? DONE : LOAD;
      end
      LOAD: begin
        cnt_d = CW'(WARMUP - 1);
        state_d = WARM;
      end
      WARM: begin
        cnt_d = cnt_q == '0 ? CW'(len_q) - 1'b1 : cnt_q - 1'b1;
        state_d = cnt_q == '0 ? RUN : WARM;
      end
      RUN: begin
        chip_out_d = gen_chip;
        chip_valid_d = 1'b1;
        chip_last_d = cnt_q == '0;
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == '0 ? DONE : RUN;
      end
      DONE: begin
        done_d = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      grant_d = '0;
    end
  end
  always_ff @(posedge clkin) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q <= '0;
      own_q <= '0;
      rr_q <= '0;
      gen_shift_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      chip_out_q <= 1'b0;
      chip_valid_q <= 1'b0;
      chip_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q <= done_d;
      own_q <= own_d;
      rr_q <= rr_d;
      gen_shift_q <= gen_shift_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      chip_out_q <= chip_out_d;
      chip_valid_q <= chip_valid_d;
      chip_last_q <= chip_last_d;
    end
  end
  assign grant = grant_q;
  assign done = done_q;
  assign busy = state_q != IDLE;
  assign gen_rstn = state_q == WARM || state_q == RUN;
  assign gen_shift = gen_shift_q;
  assign chip_out = chip_out_q;
  assign chip_valid = chip_valid_q;
  assign chip_last = chip_last_q;
endmodule

// File: tb/tb_gold_code_scheduler.sv
// tb_gold_code_scheduler: directed checks of arbitration, warm-up latency, framing, abort and reset.
module tb_gold_code_scheduler;
  logic clkin = 1'b0, rstn = 1'b0, gen_chip = 1'b0;
  logic [3:0] req = '0;
  logic [19:0] req_shift = '0;
  logic [39:0] req_len = '0;
  logic [3:0] grant, done;
  logic busy, gen_rstn, chip_out, chip_valid, chip_last;
  logic [4:0] gen_shift;
  gold_code_scheduler dut (
    .clkin(clkin), .rstn(rstn), .req(req), .req_shift(req_shift), .req_len(req_len),
    .grant(grant), .done(done), .busy(busy), .gen_rstn(gen_rstn), .gen_shift(gen_shift),
    .gen_chip(gen_chip), .chip_out(chip_out), .chip_valid(chip_valid), .chip_last(chip_last)
  );
  always #5 clkin = ~clkin;
  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [31:0] pat = 32'hB4E1_7A2D;
  logic prev_chip = 1'b0;
  logic [3:0] g_hist [0:1099];
  logic [3:0] d_hist [0:1099];
  logic [4:0] s_hist [0:1099];
  logic b_hist [0:1099];
  logic r_hist [0:1099];
  logic v_hist [0:1099];
  logic l_hist [0:1099];
  logic [3:0] dseq [0:7];
  int nv, fv, lv, nl, ll, nd, dc, ngr, nb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    prev_chip = gen_chip;
    @(posedge clkin);
    #1;
    cyc++;
    gen_chip = pat[cyc[4:0]];
  endtask

  // n counts cycles after the one in which req was raised; done drops that requester
  task automatic run(input int ncyc, input int drop_n);
    nv = 0; fv = 0; lv = 0; nl = 0; ll = 0; nd = 0; dc = 0; ngr = 0; nb = 0;
    for (int n = 1; n <= ncyc; n++) begin
      step();
      g_hist[n] = grant; d_hist[n] = done; s_hist[n] = gen_shift;
      b_hist[n] = busy; r_hist[n] = gen_rstn; v_hist[n] = chip_valid; l_hist[n] = chip_last;
      if (chip_valid) begin
        nv++;
        if (fv == 0) fv = n;
        lv = n;
        chk("chip_out vs delayed gen_chip", chip_out, prev_chip);
      end
      if (chip_last) begin
        nl++;
        ll = n;
        chk("chip_last without chip_valid", chip_valid, 1);
      end
      if (gen_rstn) ngr++;
      if (busy) nb++;
      if (done != 0) begin
        if (nd < 8) dseq[nd] = done;
        if (dc == 0) dc = n;
        nd++;
        req = req & ~done;
      end
      if (n == drop_n) req = '0;
    end
  endtask

  initial begin
    step();
    step();
    chk("reset grant", grant, 0);
    chk("reset done", done, 0);
    chk("reset busy", busy, 0);
    chk("reset gen_rstn", gen_rstn, 0);
    chk("reset gen_shift", gen_shift, 0);
    chk("reset chip_valid", chip_valid, 0);
    chk("reset chip_last", chip_last, 0);
    chk("reset chip_out", chip_out, 0);
    rstn = 1'b1;
    step();
    // single requester, len 5
    req_len[9:0] = 10'd5;
    req = 4'b0001;
    run(45, 0);
    chk("t1 grant c1", g_hist[1], 0);
    chk("t1 busy c1", b_hist[1], 1);
    chk("t1 grant c2", g_hist[2], 4'b0001);
    chk("t1 gen_rstn c2", r_hist[2], 0);
    chk("t1 gen_rstn c3", r_hist[3], 1);
    chk("t1 gen_rstn c34", r_hist[34], 1);
    chk("t1 valid count", nv, 5);
    chk("t1 first valid", fv, 36);
    chk("t1 last valid", lv, 40);
    chk("t1 chip_last count", nl, 1);
    chk("t1 chip_last cycle", ll, 40);
    chk("t1 done cycle", dc, 41);
    chk("t1 done value", dseq[0], 4'b0001);
    chk("t1 done count", nd, 1);
    chk("t1 grant held with done", g_hist[41], 4'b0001);
    chk("t1 grant cleared", g_hist[42], 0);
    chk("t1 busy cleared", b_hist[42], 0);
    // round robin from rr_ptr=0
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    req_len = {10'd0, 10'd3, 10'd0, 10'd3};
    req_shift = {5'h00, 5'h07, 5'h00, 5'h11};
    req = 4'b0101;
    run(82, 0);
    chk("t2 first grant", g_hist[2], 4'b0001);
    chk("t2 first shift", s_hist[2], 5'h11);
    chk("t2 first done cycle", dc, 39);
    chk("t2 first done", dseq[0], 4'b0001);
    chk("t2 second grant", g_hist[41], 4'b0100);
    chk("t2 second shift", s_hist[41], 5'h07);
    chk("t2 second done", dseq[1], 4'b0100);
    chk("t2 second done cycle", d_hist[78], 4'b0100);
    chk("t2 valid count", nv, 6);
    req_len = {10'd1, 10'd1, 10'd1, 10'd1};
    req = 4'b1111;
    run(160, 0);
    chk("t2 order 0", dseq[0], 4'b1000);
    chk("t2 order 1", dseq[1], 4'b0001);
    chk("t2 order 2", dseq[2], 4'b0010);
    chk("t2 order 3", dseq[3], 4'b0100);
    chk("t2 all done", nd, 4);
    // zero length
    req_len = {10'd0, 10'd0, 10'd0, 10'd0};
    req = 4'b0010;
    run(8, 0);
    chk("t3 grant", g_hist[2], 4'b0010);
    chk("t3 done", d_hist[3], 4'b0010);
    chk("t3 done count", nd, 1);
    chk("t3 gen_rstn high cycles", ngr, 0);
    chk("t3 valid count", nv, 0);
    chk("t3 busy cycles", nb, 2);
    // abort on the 5th RUN cycle
    req_len[9:0] = 10'd20;
    req = 4'b0001;
    run(50, 39);
    chk("t4 chips", nv, 5);
    chk("t4 late chip", v_hist[40], 1);
    chk("t4 no done", nd, 0);
    chk("t4 grant cleared", g_hist[40], 0);
    chk("t4 busy cleared", b_hist[40], 0);
    chk("t4 no chip after", v_hist[41], 0);
    req_len[19:10] = 10'd3;
    req = 4'b0010;
    run(45, 0);
    chk("t4 next grant", g_hist[2], 4'b0010);
    chk("t4 next chips", nv, 3);
    chk("t4 next done cycle", dc, 39);
    chk("t4 next done", dseq[0], 4'b0010);
    // reset during WARM with req held
    req_len[9:0] = 10'd2;
    req_shift[4:0] = 5'h1D;
    req = 4'b0001;
    run(10, 0);
    chk("t5 warm gen_rstn", r_hist[10], 1);
    chk("t5 warm shift", s_hist[10], 5'h1D);
    rstn = 1'b0;
    step();
    chk("t5 rst grant", grant, 0);
    chk("t5 rst busy", busy, 0);
    chk("t5 rst gen_rstn", gen_rstn, 0);
    chk("t5 rst gen_shift", gen_shift, 0);
    chk("t5 rst done", done, 0);
    chk("t5 rst chip_valid", chip_valid, 0);
    rstn = 1'b1;
    run(40, 0);
    chk("t5 restart grant c1", g_hist[1], 0);
    chk("t5 restart grant c2", g_hist[2], 4'b0001);
    chk("t5 restart first valid", fv, 36);
    chk("t5 restart chips", nv, 2);
    chk("t5 restart done cycle", dc, 38);
    // maximum length
    req_len[39:30] = 10'd1023;
    req = 4'b1000;
    run(1070, 0);
    chk("t6 chips", nv, 1023);
    chk("t6 first valid", fv, 36);
    chk("t6 last valid", lv, 1058);
    chk("t6 chip_last count", nl, 1);
    chk("t6 chip_last cycle", ll, 1058);
    chk("t6 done cycle", dc, 1059);
    chk("t6 done count", nd, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
